// File: rtl/note_envelope.sv
// Note envelope generator: attack/sustain/release level gating a tone square wave into PWM.
// Optional input synchronizers enabled by defining NOTE_ENVELOPE_SYNC_EN.
module note_envelope #(
  parameter int C_CLK_FRQ = 100_000_000,
  parameter int C_STEP_US = 1000,
  parameter int C_LVL_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gate,
  input  logic               wave,
  output logic               pwm_out,
  output logic [C_LVL_W-1:0] level,
  output logic               busy
);

  localparam int C_TICK   = (C_CLK_FRQ / 1_000_000) * C_STEP_US;
  localparam int C_TCNT_W = (C_TICK > 2) ? $clog2(C_TICK) : 1;

  localparam logic [C_TCNT_W-1:0] C_TICK_LAST = C_TCNT_W'(C_TICK - 1);
  localparam logic [C_TCNT_W-1:0] C_TCNT_ONE  = C_TCNT_W'(1);
  localparam logic [C_LVL_W-1:0]  C_LMAX      = '1;
  localparam logic [C_LVL_W-1:0]  C_LVL_ZERO  = '0;
  localparam logic [C_LVL_W-1:0]  C_LVL_ONE   = C_LVL_W'(1);

  if (C_TICK < 2) begin : g_tick_check
    $error("note_envelope: C_TICK must be at least 2");
  end

  // Conditioned inputs seen by the envelope and PWM logic
  logic gate_s;
  logic wave_s;

`ifdef NOTE_ENVELOPE_SYNC_EN
  logic [1:0] gate_ff;
  logic [1:0] wave_ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_ff <= 2'b00;
      wave_ff <= 2'b00;
    end else begin
      gate_ff <= {gate_ff[0], gate};
      wave_ff <= {wave_ff[0], wave};
    end
  end

  assign gate_s = gate_ff[1];
  assign wave_s = wave_ff[1];
`else
  assign gate_s = gate;
  assign wave_s = wave;
`endif

  // Step timebase
  logic [C_TCNT_W-1:0] tick_cnt;
  logic                tick;

  assign tick = (tick_cnt == C_TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + C_TCNT_ONE;
    end
  end

  // Envelope FSM
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_SUSTAIN = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [C_LVL_W-1:0] level_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      level <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  // A gate-driven transition always wins over a pending step in the same cycle.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    case (state)
      S_IDLE: begin
        level_nxt = C_LVL_ZERO;
        if (gate_s) begin
          state_nxt = S_ATTACK;
        end
      end
      S_ATTACK: begin
        if (!gate_s) begin
          state_nxt = S_RELEASE;
        end else if (level == C_LMAX) begin
          state_nxt = S_SUSTAIN;
        end else if (tick) begin
          level_nxt = level + C_LVL_ONE;
          if (level == C_LMAX - C_LVL_ONE) begin
            state_nxt = S_SUSTAIN;
          end
        end
      end
      S_SUSTAIN: begin
        level_nxt = C_LMAX;
        if (!gate_s) begin
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (gate_s) begin
          state_nxt = S_ATTACK;
        end else if (level == C_LVL_ZERO) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          level_nxt = level - C_LVL_ONE;
          if (level == C_LVL_ONE) begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        level_nxt = C_LVL_ZERO;
      end
    endcase
  end

  // PWM: duty is level / 2^C_LVL_W, gated by the tone wave
  logic [C_LVL_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + C_LVL_ONE;
      pwm_out <= wave_s & (pwm_cnt < level);
    end
  end

endmodule

// File: tb/tb_note_envelope.sv
// Randomized scoreboard bench for note_envelope; expected outputs come from a direction/level model.
module tb_note_envelope;

  localparam int LVL_W = 8;
  localparam int LMAX  = 255;
  localparam int TICK  = 4;
`ifdef NOTE_ENVELOPE_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic             clk  = 1'b0;
  logic             rst  = 1'b1;
  logic             gate = 1'b0;
  logic             wave = 1'b0;
  logic             pwm_out;
  logic [LVL_W-1:0] level;
  logic             busy;

  always #5 clk = ~clk;

  note_envelope #(
    .C_CLK_FRQ(1_000_000),
    .C_STEP_US(4),
    .C_LVL_W  (LVL_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .gate   (gate),
    .wave   (wave),
    .pwm_out(pwm_out),
    .level  (level),
    .busy   (busy)
  );

  // Scoreboard entries: {busy, level, pwm_out}
  logic [LVL_W+1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: the level moves toward the gate direction one step per tick;
  // any change of direction (or start from silence) costs the step of that cycle.
  int m_lvl  = 0;
  int m_tcnt = 0;
  int m_pcnt = 0;
  bit m_busy = 0;
  bit m_up   = 0;
  bit m_pwm  = 0;
  bit g1 = 0, g2 = 0, w1 = 0, w2 = 0;

  task automatic model_edge();
    bit gs, ws, tk;
    if (rst) begin
      m_lvl = 0; m_tcnt = 0; m_pcnt = 0;
      m_busy = 0; m_up = 0; m_pwm = 0;
      g1 = 0; g2 = 0; w1 = 0; w2 = 0;
    end else begin
      gs = SYNC ? g2 : gate;
      ws = SYNC ? w2 : wave;
      tk = (m_tcnt == TICK - 1);
      m_pwm  = ws && (m_pcnt < m_lvl);
      m_pcnt = (m_pcnt + 1) % (LMAX + 1);
      m_tcnt = (m_tcnt + 1) % TICK;
      g2 = g1; g1 = gate;
      w2 = w1; w1 = wave;
      if (!m_busy) begin
        m_lvl = 0;
        if (gs) begin
          m_busy = 1;
          m_up   = 1;
        end
      end else if (gs != m_up) begin
        m_up = gs;
      end else if (m_up) begin
        if (tk && m_lvl < LMAX) m_lvl = m_lvl + 1;
      end else begin
        if (m_lvl == 0) begin
          m_busy = 0;
        end else if (tk) begin
          m_lvl = m_lvl - 1;
          if (m_lvl == 0) m_busy = 0;
        end
      end
    end
  endtask

  function automatic bit rw();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one clock's worth of inputs and queue the outputs expected after the next edge
  task automatic cycle(input bit r, input bit g, input bit w);
    @(negedge clk);
    rst  = r;
    gate = g;
    wave = w;
    model_edge();
    exp_q.push_back({m_busy, 8'(m_lvl), m_pwm});
  endtask

  task automatic run_until(input bit g, input int target, input int bound);
    int i;
    i = 0;
    while (m_lvl != target && i < bound) begin
      cycle(1'b0, g, rw());
      i++;
    end
    n_vec++;
    if (m_lvl != target) begin
      n_err++;
      $display("FAIL level_reach: got level %0d after %0d cycles, wanted %0d", m_lvl, i, target);
    end
  endtask

  // Monitor: compare every registered output sample against the queue head
  initial begin
    logic [LVL_W+1:0] exp_v;
    logic [LVL_W+1:0] act_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {busy, level, pwm_out};
        n_vec++;
        if (act_v !== exp_v) begin
          n_err++;
          $display("FAIL outputs t=%0t: got busy=%0b level=%0d pwm=%0b, expected busy=%0b level=%0d pwm=%0b",
                   $time, act_v[LVL_W+1], act_v[LVL_W:1], act_v[0],
                   exp_v[LVL_W+1], exp_v[LVL_W:1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    int len;
    bit g;
    // Reset held with gate pressed and wave toggling
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, i[0]);
    repeat (3) cycle(1'b0, 1'b0, rw());
    // Full attack into sustain, then sustain with wave held high
    repeat (1040) cycle(1'b0, 1'b1, rw());
    repeat (300) cycle(1'b0, 1'b1, 1'b1);
    // Full release to idle
    repeat (1050) cycle(1'b0, 1'b0, rw());
    // Retrigger during release
    run_until(1'b1, 100, 2000);
    run_until(1'b0, 60, 2000);
    run_until(1'b1, 128, 2000);
    // Hover around mid level with fast gate flips, wave high then low
    for (int i = 0; i < 256; i++) cycle(1'b0, i[1], 1'b1);
    for (int i = 0; i < 256; i++) cycle(1'b0, i[1], 1'b0);
    // Mid-attack reset with gate held
    repeat (1100) cycle(1'b0, 1'b0, rw());
    run_until(1'b1, 200, 2000);
    cycle(1'b1, 1'b1, rw());
    repeat (60) cycle(1'b0, 1'b1, rw());
    // Random gate phrases with occasional reset
    repeat (40) begin
      g   = rw();
      len = $urandom_range(1, 300);
      repeat (len) cycle($urandom_range(0, 199) == 0, g, rw());
    end
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/note_envelope.md
NOTE_ENVELOPE -- requirements
Module: note_envelope

Interface
REQ-001 SHALL have parameter C_CLK_FRQ, default 100_000_000, meaning main clock frequency [Hz].
REQ-002 SHALL have parameter C_STEP_US, default 1000, meaning envelope step period [us].
REQ-003 SHALL have parameter C_LVL_W, default 8, meaning envelope level and PWM counter width [bits].
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port gate, input, 1 bit: key pressed (1) / released (0), asynchronous to clk.
REQ-007 SHALL have port wave, input, 1 bit: square wave from the upstream tone generator (blinker).
REQ-008 SHALL have port pwm_out, output, 1 bit: enveloped audio PWM to the speaker pin.
REQ-009 SHALL have port level, output, C_LVL_W bits: current envelope level.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 SHALL define C_TICK = (C_CLK_FRQ / 1_000_000) * C_STEP_US cycles; C_TICK < 2 is a compile-time error.
REQ-012 SHALL run a free-running tick counter 0..C_TICK-1, wrapping to 0; tick is a 1-cycle pulse when count == C_TICK-1.
REQ-013 SHALL implement states IDLE, ATTACK, SUSTAIN, RELEASE; gate_s denotes gate after the optional synchronizer (REQ-024).
REQ-014 IDLE: level = 0; gate_s=1 -> ATTACK on the next edge.
REQ-015 ATTACK: on tick, level +1; when level reaches LMAX = 2^C_LVL_W-1, -> SUSTAIN on the same edge; no wrap past LMAX.
REQ-016 SUSTAIN: level held at LMAX; gate_s=0 -> RELEASE.
REQ-017 RELEASE: on tick, level -1; when level reaches 0, -> IDLE on the same edge; no underflow.
REQ-018 ATTACK with gate_s=0 -> RELEASE immediately, decaying from the current level.
REQ-019 RELEASE with gate_s=1 -> ATTACK immediately, rising from the current level; no restart from 0.
REQ-020 Simultaneous tick and state change: the transition is taken and level is not stepped in that cycle.
REQ-021 SHALL run a free-running C_LVL_W-bit PWM counter, wrapping LMAX -> 0.
REQ-022 pwm_out SHALL be registered: pwm_out <= wave_s AND (pwm_cnt < level); at level 0 pwm_out = 0; at LMAX duty = LMAX/2^C_LVL_W while wave_s = 1.
REQ-023 level and busy SHALL be registered outputs updated on the same edge as the state.

Configuration
REQ-024 Macro NOTE_ENVELOPE_SYNC_EN: when defined, gate and wave each pass through a 2-flop synchronizer (gate_s/wave_s lag inputs by 2 cycles); when undefined, gate_s = gate and wave_s = wave combinationally (0-cycle lag). All other behaviour is identical.

Reset
REQ-025 While rst = 1 at a rising edge: state = IDLE, level = 0, busy = 0, pwm_out = 0, tick counter = 0, PWM counter = 0, synchronizer flops = 0.
REQ-026 Reset asserted mid-ATTACK/SUSTAIN/RELEASE SHALL abort to IDLE at that edge regardless of gate; after rst falls, a held gate = 1 starts a new ATTACK from level 0.

Verification (C_CLK_FRQ=1_000_000, C_STEP_US=4 -> C_TICK=4; C_LVL_W=8; NOTE_ENVELOPE_SYNC_EN defined)
REQ-027 Reset: rst = 1 for 5 cycles with gate = 1 and wave toggling -> level = 0, busy = 0, pwm_out = 0 throughout.
REQ-028 Full attack: gate 0->1 and held -> busy rises 3 cycles later; level reaches 255 and state is SUSTAIN after 255 ticks (about 1020 cycles); level stays 255.
REQ-029 Release: from SUSTAIN, gate -> 0 -> level decrements once per 4 cycles to 0, then busy = 0; level never wraps to 255.
REQ-030 Retrigger: release gate at level 100, re-press at level 60 -> level rises from 60 (61 on next tick), never passes through 0.
REQ-031 PWM: hold level 128 with wave = 1 -> pwm_out high for 128 of every 256 cycles; with wave = 0 -> pwm_out = 0 constantly.
REQ-032 Mid-operation reset: assert rst for 1 cycle at level 200 in ATTACK -> next cycle level = 0, state IDLE; with gate held, ATTACK restarts from 0.
